// File: rtl/req_ack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : req_ack_pkg
//  Purpose  : Shared types and default sizing for the multi-channel
//             req/ack responder.
//  Revision : 1.0  initial release
// ============================================================================
package req_ack_pkg;

    // Responder FSM states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_LAT_W  = 4;
    localparam int DEF_CNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin select. Returns the lowest-index
//             active request at or after the pointer, wrapping at NUM_CH-1.
//  Revision : 1.0  initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  pointer,
    output logic              valid,
    output logic [IDX_W-1:0]  winner
);

    localparam logic [IDX_W:0] c_num_ch = (IDX_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] w_rot;
    logic [IDX_W-1:0]  w_off;
    logic [IDX_W:0]    w_sum;
    logic [IDX_W:0]    w_wrap;

    // Rotate so bit 0 is the pointer's channel; doubling the vector makes the wrap free
    assign w_rot = NUM_CH'({req, req} >> pointer);

    // Priority-encode the rotated vector: lowest set offset wins
    always_comb begin
        valid = 1'b0;
        w_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                valid = 1'b1;
                w_off = IDX_W'(j);
            end
        end
    end

    // Map the offset back to an absolute channel index (mod NUM_CH)
    assign w_sum  = {1'b0, pointer} + {1'b0, w_off};
    assign w_wrap = w_sum - c_num_ch;
    assign winner = (w_sum >= c_num_ch) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/multi_ch_req_ack.sv
`default_nettype none
// ============================================================================
//  Module   : multi_ch_req_ack
//  Purpose  : Round-robin multi-channel req/ack responder with run-time
//             programmable ack latency, abort on request drop and a
//             saturating served-request counter.
//  Options  : REQ_ACK_ASSERT_EN - compile embedded handshake assertions.
//  Revision : 1.0  initial release
// ============================================================================
module multi_ch_req_ack
    import req_ack_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LAT_W  = DEF_LAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    input  logic [LAT_W-1:0]          lat_cfg,
    output logic [NUM_CH-1:0]         ack,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic [CNT_W-1:0]          served_cnt
);

    localparam int              IDX_W  = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] c_last = IDX_W'(NUM_CH - 1);

    state_e             r_state;
    logic [LAT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [NUM_CH-1:0]  r_ack;
    logic [CNT_W-1:0]   r_served;

    logic               w_valid;
    logic [IDX_W-1:0]   w_winner;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req     (req),
        .pointer (r_ptr),
        .valid   (w_valid),
        .winner  (w_winner)
    );

    // Handshake FSM with latency countdown, rr pointer and service counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_served <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_valid) begin
                        r_grant <= w_winner;
                        r_cnt   <= lat_cfg;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // A dropped request aborts silently; the pointer stays put
                    if (!req[r_grant]) begin
                        r_ack   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_ack   <= NUM_CH'(1) << r_grant;
                        r_state <= ACK;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ACK: begin
                    r_ack   <= '0;
                    r_ptr   <= (r_grant == c_last) ? '0 : r_grant + 1'b1;
                    if (r_served != '1) begin
                        r_served <= r_served + 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign busy       = (r_state != IDLE);
    assign grant_id   = r_grant;
    assign served_cnt = r_served;

`ifdef REQ_ACK_ASSERT_EN
    a_ack_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(ack));

    a_ack_pulse: assert property (@(posedge clk) disable iff (rst)
        (ack != '0) |=> (ack == '0));

    // The first sample after reset compares against a pre-reset value, so skip it
    a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (served_cnt >= $past(served_cnt)));

    a_rst_state: assert property (@(posedge clk)
        rst |=> (ack == '0 && served_cnt == '0 && !busy));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ack_req
            a_ack_has_req: assert property (@(posedge clk) disable iff (rst)
                ack[gi] |-> req[gi]);
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_ch_req_ack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_ch_req_ack
//  Purpose  : Directed self-checking bench for multi_ch_req_ack with an
//             ack scoreboard keyed on expected vector and edge number.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_ch_req_ack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] lat_cfg = '0;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] grant_id;
    logic [7:0] served_cnt;

    logic [3:0] req2 = '0;
    logic [3:0] lat2 = '0;
    logic [3:0] ack2;
    logic       busy2;
    logic [1:0] grant2;
    logic [1:0] served2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t;

    typedef struct {
        logic [3:0] vec;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multi_ch_req_ack #(.NUM_CH(4), .LAT_W(4), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lat_cfg    (lat_cfg),
        .ack        (ack),
        .busy       (busy),
        .grant_id   (grant_id),
        .served_cnt (served_cnt)
    );

    multi_ch_req_ack #(.NUM_CH(4), .LAT_W(4), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .req        (req2),
        .lat_cfg    (lat2),
        .ack        (ack2),
        .busy       (busy2),
        .grant_id   (grant2),
        .served_cnt (served2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] vec, input int at);
        exp_t e;
        e.vec = vec;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // One clock edge, then compare any ack against the scoreboard head
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_vec", {28'd0, ack}, {28'd0, e.vec});
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_served", {24'd0, served_cnt}, 32'd0);
        rst = 1'b0;

        // Test 1: reset mid-WAIT drops the pending ack
        req = 4'b0010; lat_cfg = 4'd5;
        tick();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_grant", {30'd0, grant_id}, 32'd1);
        tick();
        tick();
        rst = 1'b1; req = 4'b0000;
        tick();
        chk("t1_busy_rst", {31'd0, busy}, 32'd0);
        chk("t1_ack_rst", {28'd0, ack}, 32'd0);
        chk("t1_served_rst", {24'd0, served_cnt}, 32'd0);
        rst = 1'b0;
        repeat (10) tick();

        // Test 2: single request ch2, L=3; lat_cfg change after grant is ignored
        req = 4'b0100; lat_cfg = 4'd3;
        t = cyc + 1;
        push(4'b0100, t + 4);
        tick();
        chk("t2_grant", {30'd0, grant_id}, 32'd2);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        lat_cfg = 4'd9;
        drain(20);
        req = 4'b0000;
        tick();
        chk("t2_served", {24'd0, served_cnt}, 32'd1);
        chk("t2_grant_hold", {30'd0, grant_id}, 32'd2);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // Test 3: L=0 on ch0, held request re-requests; acks 3 cycles apart
        req = 4'b0001; lat_cfg = 4'd0;
        t = cyc + 1;
        push(4'b0001, t + 1);
        push(4'b0001, t + 4);
        drain(20);
        req = 4'b0000;
        tick();
        chk("t3_served", {24'd0, served_cnt}, 32'd3);

        // Test 4: all channels held, L=1, pointer freshly reset to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_served_rst", {24'd0, served_cnt}, 32'd0);
        req = 4'b1111; lat_cfg = 4'd1;
        t = cyc + 1;
        push(4'b0001, t + 2);
        push(4'b0010, t + 6);
        push(4'b0100, t + 10);
        push(4'b1000, t + 14);
        push(4'b0001, t + 18);
        drain(40);
        req = 4'b0000;
        tick();
        chk("t4_served", {24'd0, served_cnt}, 32'd5);
        chk("t4_grant", {30'd0, grant_id}, 32'd0);

        // Test 5: abort ch3 during WAIT, then ch3 still beats ch0 from pointer 1
        req = 4'b1000; lat_cfg = 4'd6;
        tick();
        chk("t5_grant", {30'd0, grant_id}, 32'd3);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("t5_abort_idle", {31'd0, busy}, 32'd0);
        chk("t5_abort_served", {24'd0, served_cnt}, 32'd5);
        req = 4'b1001; lat_cfg = 4'd0;
        t = cyc + 1;
        push(4'b1000, t + 1);
        push(4'b0001, t + 4);
        drain(20);
        req = 4'b0000;
        tick();
        chk("t5_served", {24'd0, served_cnt}, 32'd7);

        // Test 6: 2-bit counter saturates at 3
        req2 = 4'b0001; lat2 = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            int n = 0;
            while (ack2 === 4'b0000 && n < 10) begin
                tick();
                n++;
            end
            chk("t6_ack2", {28'd0, ack2}, 32'd1);
            tick();
            chk("t6_served", {30'd0, served2}, (k < 3) ? k : 3);
        end
        req2 = 4'b0000;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
